serial_regbank: RTL and testbench
=================================

SERIAL_REGBANK -- requirements
Module: serial_regbank

Interface
REQ-001 Parameter REG_WIDTH, default 8, bits per register; SHALL be >=2.
REQ-002 Parameter REG_COUNT, default 8, number of registers; SHALL be a power of two >=2.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 SHALL read as all-zero and ignore every write.
REQ-004 Address width AW SHALL be clog2(REG_COUNT) and index width IW SHALL be clog2(REG_WIDTH).
REQ-005 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 Port rstn, input, 1, reset, asynchronous and active-low.
REQ-007 Port start, input, 1, request a serial transaction; sampled only in IDLE or DONE.
REQ-008 Port rs1_addr, rs2_addr, rd_addr, input, AW each, source/destination addresses, latched on accepted start.
REQ-009 Port wr_mode, input, 1, latched on accepted start; 1 = transaction writes rd, 0 = read-only.
REQ-010 Port wr_en, input, 1, qualifies wr_bit in the current SHIFT cycle.
REQ-011 Port wr_bit, input, 1, serial write-back bit.
REQ-012 Port rs1_bit, rs2_bit, output, 1 each, current bit of latched rs1/rs2.
REQ-013 Port bit_idx, output, IW, index of the bit currently presented.
REQ-014 Port busy, output, 1, high exactly in SHIFT.
REQ-015 Port done, output, 1, single-cycle pulse, high exactly in DONE.
REQ-016 Port pl_en, pl_addr (AW), pl_data (REG_WIDTH), input, parallel load of one full register.
REQ-017 Port dbg_addr (AW) input, dbg_data (REG_WIDTH) output, combinational full-register readout.

Function
REQ-018 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-019 IDLE->SHIFT on start=1: latch addresses and wr_mode; set bit_idx=0.
REQ-020 SHIFT: bit_idx SHALL increment by 1 per cycle, LSB first; on the edge with bit_idx=REG_WIDTH-1 the FSM SHALL go to DONE and bit_idx SHALL wrap to 0.
REQ-021 SHIFT SHALL last exactly REG_WIDTH cycles; DONE exactly one cycle.
REQ-022 DONE->SHIFT if start=1 (back-to-back, new addresses latched), else DONE->IDLE.
REQ-023 start in SHIFT SHALL be ignored; no queuing.
REQ-024 In SHIFT, rs1_bit/rs2_bit SHALL equal regs[rs1][bit_idx]/regs[rs2][bit_idx]; outside SHIFT both SHALL be 0.
REQ-025 In SHIFT with wr_mode=1 and wr_en=1, regs[rd][bit_idx] SHALL take wr_bit at the clock edge; wr_en outside SHIFT or with wr_mode=0 SHALL be ignored.
REQ-026 rd equal to rs1 or rs2: read SHALL return the pre-edge value for the current bit (read-before-write).
REQ-027 Parallel load SHALL occur only in IDLE; pl_en in SHIFT or DONE SHALL be dropped silently.
REQ-028 pl_en and start in the same IDLE cycle: both SHALL take effect; the transaction SHALL see loaded data from its first bit.
REQ-029 dbg_data SHALL reflect register contents combinationally, including ZERO_REG masking.

Reset
REQ-030 rstn low SHALL force IDLE, bit_idx=0, busy=0, done=0, rs1_bit=rs2_bit=0, all registers and latched addresses to 0, immediately and independent of clk.
REQ-031 Reset during SHIFT SHALL abort the transaction; no partial write SHALL survive; no done pulse.
REQ-032 After rstn rises, the first start SHALL be accepted on the first rising edge.

Structure
REQ-033 A shared package regfile_pkg SHALL hold the FSM state encoding (IDLE=0, SHIFT=1, DONE=2, 2 bits) and the default REG_WIDTH/REG_COUNT constants.
REQ-034 The bit-index counter with wrap and terminal-count flag SHALL be the sub-module serial_bit_counter, parametrised by REG_WIDTH.

Verification
REQ-035 Reset, pl load r3=0xA5, start rs1=3 wr_mode=0 -> rs1_bit sequence 1,0,1,0,0,1,0,1 over 8 cycles, done at cycle 9.
REQ-036 start rs1=2 rd=2 wr_mode=1, wr_bit=~rs1_bit every cycle, r2=0x0F -> dbg_data(r2)=0xF0 after done.
REQ-037 ZERO_REG=1: pl load r0=0xFF then serial write all-ones to r0 -> dbg_data(r0)=0x00, rs1_bit always 0.
REQ-038 Back-to-back: start held high through DONE -> SHIFT re-entered with no IDLE cycle, done pulses 9 cycles apart.
REQ-039 rstn low at bit_idx=4 during write of r5 -> r5=0x00, state IDLE, done never asserted.
REQ-040 pl_en during SHIFT with pl_data=0x3C -> target register unchanged; REG_WIDTH=16, REG_COUNT=4 rerun of REQ-035 passes.

Source files
------------

// File: rtl/serial_regbank_pkg.sv
// regfile_pkg: shared definitions for the serial register bank.
//   - state_e            : FSM state encoding (IDLE=0, SHIFT=1, DONE=2, 2 bits)
//   - DEFAULT_REG_WIDTH  : default bits per register
//   - DEFAULT_REG_COUNT  : default number of registers
package regfile_pkg;

    localparam int unsigned DEFAULT_REG_WIDTH = 8;
    localparam int unsigned DEFAULT_REG_COUNT = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_regbank_if.sv
// serial_regbank_if: transaction, write-back, parallel-load and debug signals of the
// serial register bank.
//   master : drives start/addresses/wr_mode/wr_en/wr_bit/pl_*/dbg_addr, observes results
//   slave  : the register bank itself
interface serial_regbank_if
    import regfile_pkg::*;
#(
    parameter int unsigned REG_WIDTH = DEFAULT_REG_WIDTH,
    parameter int unsigned REG_COUNT = DEFAULT_REG_COUNT
);
    localparam int unsigned AW = $clog2(REG_COUNT);
    localparam int unsigned IW = $clog2(REG_WIDTH);

    logic                 start;
    logic [AW-1:0]        rs1_addr;
    logic [AW-1:0]        rs2_addr;
    logic [AW-1:0]        rd_addr;
    logic                 wr_mode;
    logic                 wr_en;
    logic                 wr_bit;
    logic                 rs1_bit;
    logic                 rs2_bit;
    logic [IW-1:0]        bit_idx;
    logic                 busy;
    logic                 done;
    logic                 pl_en;
    logic [AW-1:0]        pl_addr;
    logic [REG_WIDTH-1:0] pl_data;
    logic [AW-1:0]        dbg_addr;
    logic [REG_WIDTH-1:0] dbg_data;

    modport master (
        output start, rs1_addr, rs2_addr, rd_addr, wr_mode, wr_en, wr_bit,
        output pl_en, pl_addr, pl_data, dbg_addr,
        input  rs1_bit, rs2_bit, bit_idx, busy, done, dbg_data
    );

    modport slave (
        input  start, rs1_addr, rs2_addr, rd_addr, wr_mode, wr_en, wr_bit,
        input  pl_en, pl_addr, pl_data, dbg_addr,
        output rs1_bit, rs2_bit, bit_idx, busy, done, dbg_data
    );

endinterface

// File: rtl/serial_bit_counter.sv
// serial_bit_counter: bit index for serial transfers, 0..WIDTH-1 with wrap.
//   clk, rstn : clock, async active-low reset
//   clear     : force index to 0
//   en        : advance index (wraps to 0 after WIDTH-1)
//   idx       : current bit index
//   last      : terminal count, idx == WIDTH-1
module serial_bit_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     last
);
    localparam int unsigned IW = $clog2(WIDTH);

    logic [IW-1:0] idx_q, idx_d;

    assign last = (idx_q == IW'(WIDTH - 1));
    assign idx  = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (en) begin
            idx_d = last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/serial_regbank.sv
// serial_regbank: register bank read and written one bit per cycle, LSB first.
//   clk, rstn : clock, async active-low reset
//   bus       : serial_regbank_if slave modport
//       start/rs1_addr/rs2_addr/rd_addr/wr_mode : transaction request (IDLE or DONE only)
//       wr_en/wr_bit                             : serial write-back during SHIFT
//       rs1_bit/rs2_bit/bit_idx                  : current source bits and bit index
//       busy/done                                : SHIFT indicator / one-cycle DONE pulse
//       pl_en/pl_addr/pl_data                    : full-register load, IDLE only
//       dbg_addr/dbg_data                        : combinational full-register readout
module serial_regbank
    import regfile_pkg::*;
#(
    parameter int unsigned REG_WIDTH = DEFAULT_REG_WIDTH,
    parameter int unsigned REG_COUNT = DEFAULT_REG_COUNT,
    parameter int unsigned ZERO_REG  = 1
) (
    input logic             clk,
    input logic             rstn,
    serial_regbank_if.slave bus
);
    localparam int unsigned AW = $clog2(REG_COUNT);
    localparam int unsigned IW = $clog2(REG_WIDTH);

    state_e               state_q, state_d;
    logic                 accept;
    logic                 last_bit;
    logic [IW-1:0]        bit_idx;
    logic [AW-1:0]        rs1_q, rs2_q, rd_q;
    logic                 wr_mode_q;
    logic [REG_WIDTH-1:0] regs_q [REG_COUNT];
    logic [REG_WIDTH-1:0] regs_d [REG_COUNT];
    logic [REG_WIDTH-1:0] rs1_word, rs2_word;
    logic                 in_shift;
    logic                 pl_fire, wr_fire;

    function automatic logic writable(input logic [AW-1:0] addr);
        return !((ZERO_REG != 0) && (addr == '0));
    endfunction

    // Register 0 is hard-wired to zero when ZERO_REG is set.
    function automatic logic [REG_WIDTH-1:0] read_word(input logic [AW-1:0] addr);
        return writable(addr) ? regs_q[addr] : '0;
    endfunction

    // FSM next state; accept marks a latched start (from IDLE or DONE).
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StShift;
                    accept  = 1'b1;
                end
            end
            StShift: begin
                if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.start) begin
                    state_d = StShift;
                    accept  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_shift = (state_q == StShift);

    serial_bit_counter #(
        .WIDTH (REG_WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rstn  (rstn),
        .clear (accept),
        .en    (in_shift),
        .idx   (bit_idx),
        .last  (last_bit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wr_mode_q <= 1'b0;
        end else if (accept) begin
            rs1_q     <= bus.rs1_addr;
            rs2_q     <= bus.rs2_addr;
            rd_q      <= bus.rd_addr;
            wr_mode_q <= bus.wr_mode;
        end
    end

    // Loads and serial writes live in mutually exclusive states, so they never collide.
    assign pl_fire = (state_q == StIdle) && bus.pl_en && writable(bus.pl_addr);
    assign wr_fire = in_shift && wr_mode_q && bus.wr_en && writable(rd_q);

    always_comb begin
        regs_d = regs_q;
        if (pl_fire) begin
            regs_d[bus.pl_addr] = bus.pl_data;
        end
        if (wr_fire) begin
            regs_d[rd_q][bit_idx] = bus.wr_bit;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads come from regs_q, so a same-register write is seen only from the next bit on.
    assign rs1_word     = read_word(rs1_q);
    assign rs2_word     = read_word(rs2_q);
    assign bus.rs1_bit  = in_shift & rs1_word[bit_idx];
    assign bus.rs2_bit  = in_shift & rs2_word[bit_idx];
    assign bus.bit_idx  = bit_idx;
    assign bus.busy     = in_shift;
    assign bus.done     = (state_q == StDone);
    assign bus.dbg_data = read_word(bus.dbg_addr);

endmodule

// File: tb/tb_serial_regbank.sv
// tb_serial_regbank: directed and random transactions on an 8x8 bank (ZERO_REG=1) checked
// against an array model; a 16x4 bank (ZERO_REG=0) reruns the 0xA5 readout.
module tb_serial_regbank;
    import regfile_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #10 clk = ~clk;

    serial_regbank_if #(.REG_WIDTH(8),  .REG_COUNT(8)) bus ();
    serial_regbank_if #(.REG_WIDTH(16), .REG_COUNT(4)) bus2 ();

    serial_regbank #(.REG_WIDTH(8), .REG_COUNT(8), .ZERO_REG(1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    serial_regbank #(.REG_WIDTH(16), .REG_COUNT(4), .ZERO_REG(0)) dut2 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2)
    );

    int         total      = 0;
    int         bad        = 0;
    int         cyc        = 0;
    int         last_done  = 0;
    bit         prev_chain = 1'b0;
    logic [7:0] m [8];

    function automatic logic [7:0] mread(input int a);
        return (a == 0) ? 8'h00 : m[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all_dbg();
        for (int a = 0; a < 8; a++) begin
            bus.dbg_addr = a[2:0];
            #1;
            check("dbg_data", {24'h0, bus.dbg_data}, {24'h0, mread(a)});
        end
    endtask

    task automatic pl_load(input int a, input logic [7:0] d);
        bus.pl_en   = 1'b1;
        bus.pl_addr = a[2:0];
        bus.pl_data = d;
        step();
        bus.pl_en = 1'b0;
        if (a != 0) m[a] = d;
        bus.dbg_addr = a[2:0];
        #1;
        check("pl_load", {24'h0, bus.dbg_data}, {24'h0, mread(a)});
    endtask

    task automatic idle_step();
        bus.start = 1'b0;
        step();
        bus.pl_en = 1'b0;
        check("idle_busy", {31'h0, bus.busy}, 0);
        check("idle_done", {31'h0, bus.done}, 0);
    endtask

    // Issues start now (bench in IDLE or DONE); returns at the DONE sample point.
    task automatic run_txn(input int a1, input int a2, input int ad, input bit wm,
                           input logic [7:0] wb, input logic [7:0] we,
                           input bit chain, input bit noise);
        bus.start    = 1'b1;
        bus.rs1_addr = a1[2:0];
        bus.rs2_addr = a2[2:0];
        bus.rd_addr  = ad[2:0];
        bus.wr_mode  = wm;
        step();
        bus.start = 1'b0;
        bus.pl_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("busy", {31'h0, bus.busy}, 1);
            check("done_low", {31'h0, bus.done}, 0);
            check("bit_idx", {29'h0, bus.bit_idx}, i);
            check("rs1_bit", {31'h0, bus.rs1_bit}, (mread(a1) >> i) & 1);
            check("rs2_bit", {31'h0, bus.rs2_bit}, (mread(a2) >> i) & 1);
            bus.wr_en  = we[i];
            bus.wr_bit = wb[i];
            if (noise) begin
                bus.start   = 1'($urandom_range(0, 1));
                bus.pl_en   = 1'($urandom_range(0, 1));
                bus.pl_addr = 3'($urandom);
                bus.pl_data = 8'($urandom);
            end
            if (i == 7) bus.start = chain;
            step();
            if (wm && we[i] && ad != 0) m[ad][i] = wb[i];
        end
        bus.wr_en = 1'b0;
        bus.pl_en = 1'b0;
        check("done", {31'h0, bus.done}, 1);
        check("done_busy", {31'h0, bus.busy}, 0);
        check("done_rs1", {31'h0, bus.rs1_bit}, 0);
        check("done_rs2", {31'h0, bus.rs2_bit}, 0);
        check("done_idx", {29'h0, bus.bit_idx}, 0);
        if (prev_chain) check("done_gap", cyc - last_done, 9);
        last_done  = cyc;
        prev_chain = chain;
        // A load offered during DONE must be dropped.
        if (!chain && noise) begin
            bus.pl_en   = 1'b1;
            bus.pl_addr = 3'($urandom);
            bus.pl_data = 8'($urandom);
        end
    endtask

    initial begin
        logic [15:0] pat2;
        logic [15:0] pat0;
        bit          chained;
        bit          c;

        bus.start = 0; bus.rs1_addr = 0; bus.rs2_addr = 0; bus.rd_addr = 0;
        bus.wr_mode = 0; bus.wr_en = 0; bus.wr_bit = 0;
        bus.pl_en = 0; bus.pl_addr = 0; bus.pl_data = 0; bus.dbg_addr = 0;
        bus2.start = 0; bus2.rs1_addr = 0; bus2.rs2_addr = 0; bus2.rd_addr = 0;
        bus2.wr_mode = 0; bus2.wr_en = 0; bus2.wr_bit = 0;
        bus2.pl_en = 0; bus2.pl_addr = 0; bus2.pl_data = 0; bus2.dbg_addr = 0;
        for (int i = 0; i < 8; i++) m[i] = 8'h00;

        // Asynchronous reset before any clock edge.
        #2 rstn = 1'b0;
        #2;
        check("rst_busy", {31'h0, bus.busy}, 0);
        check("rst_done", {31'h0, bus.done}, 0);
        check("rst_idx", {29'h0, bus.bit_idx}, 0);
        check("rst_rs1", {31'h0, bus.rs1_bit}, 0);
        check("rst_rs2", {31'h0, bus.rs2_bit}, 0);
        check_all_dbg();
        step();
        step();
        rstn = 1'b1;

        // Load and start together on the first edge after reset; r3=0xA5 read LSB first.
        bus.pl_en   = 1'b1;
        bus.pl_addr = 3'd3;
        bus.pl_data = 8'hA5;
        m[3]        = 8'hA5;
        run_txn(3, 3, 0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
        idle_step();

        // Invert r2 in place through the serial write-back.
        pl_load(2, 8'h0F);
        run_txn(2, 2, 2, 1'b1, ~8'h0F, 8'hFF, 1'b0, 1'b0);
        idle_step();
        bus.dbg_addr = 3'd2;
        #1;
        check("invert_r2", {24'h0, bus.dbg_data}, 32'hF0);

        // Register 0 ignores both load and serial write.
        pl_load(0, 8'hFF);
        run_txn(0, 0, 0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        idle_step();
        bus.dbg_addr = 3'd0;
        #1;
        check("zero_reg", {24'h0, bus.dbg_data}, 0);

        // Back-to-back with start held through DONE.
        pl_load(1, 8'h5A);
        run_txn(1, 2, 3, 1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b1);
        run_txn(3, 1, 4, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
        idle_step();
        check_all_dbg();

        // Random traffic.
        chained = 1'b0;
        repeat (20) begin
            if (!chained && ($urandom_range(0, 1) == 1)) pl_load($urandom_range(0, 7), 8'($urandom));
            c = ($urandom_range(0, 2) == 0);
            run_txn($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), c, 1'b1);
            if (!c) begin
                idle_step();
                check_all_dbg();
            end
            chained = c;
        end
        if (chained) begin
            run_txn(1, 2, 5, 1'b1, 8'($urandom), 8'hFF, 1'b0, 1'b1);
            idle_step();
            check_all_dbg();
        end

        // Reset in the middle of writing r5.
        bus.start    = 1'b1;
        bus.rs1_addr = 3'd5;
        bus.rs2_addr = 3'd5;
        bus.rd_addr  = 3'd5;
        bus.wr_mode  = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en  = 1'b1;
            bus.wr_bit = 1'b1;
            step();
        end
        check("abort_idx", {29'h0, bus.bit_idx}, 4);
        bus.wr_en = 1'b0;
        #2 rstn = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        check("abort_busy", {31'h0, bus.busy}, 0);
        check("abort_done", {31'h0, bus.done}, 0);
        check("abort_idx0", {29'h0, bus.bit_idx}, 0);
        check("abort_rs1", {31'h0, bus.rs1_bit}, 0);
        step();
        rstn = 1'b1;
        repeat (10) begin
            step();
            check("abort_no_done", {31'h0, bus.done}, 0);
            check("abort_idle", {31'h0, bus.busy}, 0);
        end
        check_all_dbg();

        // 16x4 bank without a zero register.
        bus2.pl_en   = 1'b1;
        bus2.pl_addr = 2'd0;
        bus2.pl_data = 16'h1234;
        step();
        bus2.pl_addr = 2'd3;
        bus2.pl_data = 16'h00A5;
        step();
        bus2.pl_en    = 1'b0;
        bus2.dbg_addr = 2'd0;
        #1;
        check("w16_r0", {16'h0, bus2.dbg_data}, 32'h1234);
        bus2.dbg_addr = 2'd3;
        #1;
        check("w16_r3", {16'h0, bus2.dbg_data}, 32'h00A5);
        pat2 = 16'h00A5;
        pat0 = 16'h1234;
        bus2.start    = 1'b1;
        bus2.rs1_addr = 2'd3;
        bus2.rs2_addr = 2'd0;
        step();
        bus2.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("w16_busy", {31'h0, bus2.busy}, 1);
            check("w16_idx", {28'h0, bus2.bit_idx}, i);
            check("w16_rs1", {31'h0, bus2.rs1_bit}, {31'h0, pat2[i]});
            check("w16_rs2", {31'h0, bus2.rs2_bit}, {31'h0, pat0[i]});
            // Load during SHIFT must be dropped.
            bus2.pl_en   = (i == 5);
            bus2.pl_addr = 2'd3;
            bus2.pl_data = 16'h3C3C;
            step();
        end
        bus2.pl_en = 1'b0;
        check("w16_done", {31'h0, bus2.done}, 1);
        step();
        check("w16_done_pulse", {31'h0, bus2.done}, 0);
        bus2.dbg_addr = 2'd3;
        #1;
        check("w16_pl_dropped", {16'h0, bus2.dbg_data}, 32'h00A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
